// File: rtl/barrel_shifter_64_bit_if.sv
// Operand/result bundle for the 64-bit shift unit.
// No handshake: the producer presents an operation every cycle, and the shifter accepts it unconditionally; the result follows one clock later.
interface barrel_shifter_64_bit_if;
  logic [63:0] d_in;
  logic [5:0]  sh_amt;
  logic        dir;      // 0 = left, 1 = right
  logic        sh_type;  // 0 = logical, 1 = arithmetic ("type" is a reserved word)
  logic [63:0] d_out;
  logic        z;

  modport master (output d_in, output sh_amt, output dir, output sh_type,
                  input d_out, input z);
  modport slave  (input d_in, input sh_amt, input dir, input sh_type,
                  output d_out, output z);
endinterface

// File: rtl/barrel_shifter_64_bit.sv
// 64-bit logarithmic barrel shifter with registered result and zero flag.
// Six right-shift stages (LSB first); left shifts reuse them via bit reversal.
module barrel_shifter_64_bit (
  input  logic                           clk,
  input  logic                           rst,
  barrel_shifter_64_bit_if.slave         bus
);

  function automatic logic [63:0] bit_rev(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  logic [63:0] stage [0:6];
  logic        fill;
  logic [63:0] result;

  // Sign fill only for arithmetic right shifts; left shifts always shift in zeros.
  assign fill     = bus.dir & bus.sh_type & bus.d_in[63];
  assign stage[0] = bus.dir ? bus.d_in : bit_rev(bus.d_in);

  for (genvar k = 0; k < 6; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = bus.sh_amt[k] ? {{SH{fill}}, stage[k][63:SH]} : stage[k];
  end

  assign result = bus.dir ? stage[6] : bit_rev(stage[6]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.d_out <= 64'h0;
      bus.z     <= 1'b1;
    end else begin
      bus.d_out <= result;
      bus.z     <= (result == 64'h0);
    end
  end

endmodule

// File: tb/tb_barrel_shifter_64_bit.sv
// Self-checking bench for barrel_shifter_64_bit: directed vectors, random
// operations against an arithmetic reference model, back-to-back and reset cases.
module tb_barrel_shifter_64_bit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [63:0] exp_q[$];

  barrel_shifter_64_bit_if bus();

  barrel_shifter_64_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain shift arithmetic, sign fill built from a mask
  function automatic logic [63:0] model(input logic [63:0] d, input int s,
                                        input logic dr, input logic t);
    logic [63:0] ones;
    ones = '1;
    if (!dr) return d << s;
    if (!t || !d[63]) return d >> s;
    return (d >> s) | ~(ones >> s);
  endfunction

  // driver: present an operation just after the falling edge
  task automatic drive_op(input logic [63:0] d, input logic [5:0] s,
                          input logic dr, input logic t);
    @(negedge clk);
    bus.d_in    = d;
    bus.sh_amt  = s;
    bus.dir     = dr;
    bus.sh_type = t;
  endtask

  task automatic wait_result();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.d_in = 64'hDEAD_BEEF_0000_0001; bus.sh_amt = 6'd4; bus.dir = 1'b0; bus.sh_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.d_out !== 64'h0 || bus.z !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: d_out=%h z=%b, expected 0 z=1", bus.d_out, bus.z);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] dv [8];
    logic [5:0]  sv [8];
    logic        drv[8];
    logic        tv [8];
    logic [63:0] ev [8];
    dv[0]=64'h5;                   sv[0]=6'd3;  drv[0]=0; tv[0]=0; ev[0]=64'h28;
    dv[1]=64'h20;                  sv[1]=6'd2;  drv[1]=1; tv[1]=0; ev[1]=64'h8;
    dv[2]=64'hFFFF_FFFF_FFFF_FFF0; sv[2]=6'd2;  drv[2]=1; tv[2]=1; ev[2]=64'hFFFF_FFFF_FFFF_FFFC;
    dv[3]=64'h1234_5678_9ABC_DEF0; sv[3]=6'd0;  drv[3]=0; tv[3]=0; ev[3]=64'h1234_5678_9ABC_DEF0;
    dv[4]=64'h1;                   sv[4]=6'd1;  drv[4]=1; tv[4]=0; ev[4]=64'h0;
    dv[5]=64'h8000_0000_0000_0000; sv[5]=6'd63; drv[5]=1; tv[5]=1; ev[5]=64'hFFFF_FFFF_FFFF_FFFF;
    dv[6]=64'h8000_0000_0000_0000; sv[6]=6'd63; drv[6]=1; tv[6]=0; ev[6]=64'h1;
    dv[7]=64'h0000_0000_0000_0003; sv[7]=6'd63; drv[7]=0; tv[7]=1; ev[7]=64'h8000_0000_0000_0000;
    for (int i = 0; i < 8; i++) begin
      drive_op(dv[i], sv[i], drv[i], tv[i]);
      wait_result();
      n_tests++;
      if (bus.d_out !== ev[i] || bus.z !== (ev[i] == 64'h0)) begin
        n_fail++;
        $display("FAIL directed[%0d]: d_out=%h z=%b, expected %h z=%b",
                 i, bus.d_out, bus.z, ev[i], (ev[i] == 64'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] d, e;
    logic [5:0]  s;
    logic        dr, t;
    for (int i = 0; i < 300; i++) begin
      d  = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) d = 64'h0;
      case ($urandom_range(0, 5))
        0:       s = 6'd0;
        1:       s = 6'd63;
        default: s = 6'($urandom_range(0, 63));
      endcase
      dr = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      e  = model(d, int'(s), dr, t);
      drive_op(d, s, dr, t);
      wait_result();
      n_tests++;
      if (bus.d_out !== e || bus.z !== (e == 64'h0)) begin
        n_fail++;
        $display("FAIL random d=%h s=%0d dir=%b type=%b: d_out=%h z=%b, expected %h z=%b",
                 d, s, dr, t, bus.d_out, bus.z, e, (e == 64'h0));
      end
    end
  endtask

  // new operation every cycle, scoreboard queue tracks the one-cycle latency
  task automatic test_back_to_back();
    logic [63:0] d, e;
    logic [5:0]  s;
    logic        dr, t;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      d  = {$urandom, $urandom};
      s  = 6'(i);
      dr = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      drive_op(d, s, dr, t);
      exp_q.push_back(model(d, i, dr, t));
      wait_result();
      e = exp_q.pop_front();
      n_tests++;
      if (bus.d_out !== e || bus.z !== (e == 64'h0)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: d_out=%h z=%b, expected %h", i, bus.d_out, bus.z, e);
      end
    end
    // hold: stable inputs keep the output stable
    e = model(d, int'(s), dr, t);
    repeat (3) begin
      wait_result();
      n_tests++;
      if (bus.d_out !== e) begin
        n_fail++;
        $display("FAIL hold: d_out=%h, expected %h", bus.d_out, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] e;
    drive_op(64'hF0F0_0000_0000_000F, 6'd4, 1'b0, 1'b0);
    wait_result();
    n_tests++;
    if (bus.d_out !== 64'h0F00_0000_0000_00F0) begin
      n_fail++;
      $display("FAIL mid_reset_pre: d_out=%h, expected 0f000000000000f0", bus.d_out);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.d_out !== 64'h0 || bus.z !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_async: d_out=%h z=%b, expected 0 z=1", bus.d_out, bus.z);
    end
    drive_op(64'h8000_0000_0000_0010, 6'd4, 1'b1, 1'b1);
    wait_result();
    n_tests++;
    if (bus.d_out !== 64'h0 || bus.z !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_held: d_out=%h z=%b, expected 0 z=1", bus.d_out, bus.z);
    end
    @(negedge clk);
    rst = 1'b0;
    e = 64'hF800_0000_0000_0001;
    wait_result();
    n_tests++;
    if (bus.d_out !== e || bus.z !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: d_out=%h z=%b, expected %h z=0", bus.d_out, bus.z, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
